// File: rtl/core_cycle_ctrl.sv
// core_cycle_ctrl: read-regenerate cycle sequencer for the 1620 core array model.
// Two requesters (CPU digit-pair path and I/O channel) share the array. Grants
// alternate when both requesters are active. Each cycle runs RD -> STROBE -> WR -> ACK.
// A destructive read is always followed by a write-back, which is either the
// sensed data or the requester's write data.
// Optional build macro CORE_PARITY_CHECK_EN adds a sticky parity_err output. It
// flags any sensed digit whose six bits (C,F,8,4,2,1) do not have odd parity.
module core_cycle_ctrl #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 12,
  parameter int MEM_PAIRS = 10000,
  parameter int T_RD      = 4,
  parameter int T_WR      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] core_addr,
  output logic              rd_drive,
  output logic              sense_strobe,
  output logic              wr_drive,
  output logic [DATA_W-1:0] inhibit,
  input  logic [DATA_W-1:0] sense
`ifdef CORE_PARITY_CHECK_EN
  ,
  output logic              parity_err
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_ACK    = 3'd4;

  localparam int T_MAX = (T_RD > T_WR) ? T_RD : T_WR;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD    = CNT_W'(T_RD - 1);
  localparam logic [CNT_W-1:0] WR_LOAD    = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W:0]  PAIR_LIMIT = (ADDR_W+1)'(MEM_PAIRS);

`ifdef CORE_PARITY_CHECK_EN
  // True when every 6-bit digit of d carries odd parity.
  function automatic logic digits_odd(input logic [DATA_W-1:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DATA_W / 6; i++) begin
      ok = ok & (^d[i*6 +: 6]);
    end
    return ok;
  endfunction
`endif

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_io_q, last_io_d;
  logic              gnt_io_q, gnt_io_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] core_addr_q, core_addr_d;
  logic              rd_drive_q, rd_drive_d;
  logic              strobe_q, strobe_d;
  logic              wr_drive_q, wr_drive_d;
  logic [DATA_W-1:0] inhibit_q, inhibit_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              io_ack_q, io_ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
`ifdef CORE_PARITY_CHECK_EN
  logic              parity_q, parity_d;
`endif

  // Arbitration: a lone request wins; on a tie the side not granted last wins.
  logic              grant_io_s, grant_cpu_s, grant_any_s;
  logic              sel_we_s, sel_oor_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  assign grant_io_s  = io_req & (~cpu_req | ~last_io_q);
  assign grant_cpu_s = cpu_req & (~io_req | last_io_q);
  assign grant_any_s = grant_io_s | grant_cpu_s;
  assign sel_we_s    = grant_io_s ? io_we    : cpu_we;
  assign sel_addr_s  = grant_io_s ? io_addr  : cpu_addr;
  assign sel_wdata_s = grant_io_s ? io_wdata : cpu_wdata;
  assign sel_oor_s   = ({1'b0, sel_addr_s} >= PAIR_LIMIT);

  // Next-state and next-output decode of the core cycle sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_io_d   = last_io_q;
    gnt_io_d    = gnt_io_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    core_addr_d = core_addr_q;
    rd_drive_d  = 1'b0;
    strobe_d    = 1'b0;
    wr_drive_d  = 1'b0;
    inhibit_d   = {DATA_W{1'b0}};
    cpu_ack_d   = 1'b0;
    io_ack_d    = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
`ifdef CORE_PARITY_CHECK_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_any_s) begin
          last_io_d   = grant_io_s;
          gnt_io_d    = grant_io_s;
          we_d        = sel_we_s;
          wdata_d     = sel_wdata_s;
          core_addr_d = sel_addr_s;
          if (sel_oor_s) begin
            // Out-of-range: complete at once without touching the stack.
            state_d   = S_ACK;
            cpu_ack_d = grant_cpu_s;
            io_ack_d  = grant_io_s;
            rdata_d   = {DATA_W{1'b0}};
            err_d     = 1'b1;
          end else begin
            state_d    = S_RD;
            cnt_d      = RD_LOAD;
            rd_drive_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d  = S_STROBE;
          strobe_d = 1'b1;
        end else begin
          cnt_d      = cnt_q - CNT_ONE;
          rd_drive_d = 1'b1;
        end
      end
      S_STROBE: begin
        // Sensed data is captured here. Regeneration writes it straight back.
        data_d     = sense;
        state_d    = S_WR;
        cnt_d      = WR_LOAD;
        wr_drive_d = 1'b1;
        inhibit_d  = ~(we_q ? wdata_q : sense);
`ifdef CORE_PARITY_CHECK_EN
        parity_d   = parity_q | ~digits_odd(sense);
`endif
      end
      S_WR: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d   = S_ACK;
          cpu_ack_d = ~gnt_io_q;
          io_ack_d  = gnt_io_q;
          rdata_d   = data_q;
          err_d     = 1'b0;
        end else begin
          cnt_d      = cnt_q - CNT_ONE;
          wr_drive_d = 1'b1;
          inhibit_d  = inhibit_q;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset drops every drive line immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      last_io_q   <= 1'b1;
      gnt_io_q    <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= {DATA_W{1'b0}};
      data_q      <= {DATA_W{1'b0}};
      core_addr_q <= {ADDR_W{1'b0}};
      rd_drive_q  <= 1'b0;
      strobe_q    <= 1'b0;
      wr_drive_q  <= 1'b0;
      inhibit_q   <= {DATA_W{1'b0}};
      cpu_ack_q   <= 1'b0;
      io_ack_q    <= 1'b0;
      rdata_q     <= {DATA_W{1'b0}};
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CORE_PARITY_CHECK_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_io_q   <= last_io_d;
      gnt_io_q    <= gnt_io_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      core_addr_q <= core_addr_d;
      rd_drive_q  <= rd_drive_d;
      strobe_q    <= strobe_d;
      wr_drive_q  <= wr_drive_d;
      inhibit_q   <= inhibit_d;
      cpu_ack_q   <= cpu_ack_d;
      io_ack_q    <= io_ack_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
`ifdef CORE_PARITY_CHECK_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign cpu_ack      = cpu_ack_q;
  assign io_ack       = io_ack_q;
  assign rdata        = rdata_q;
  assign err          = err_q;
  assign busy         = busy_q;
  assign core_addr    = core_addr_q;
  assign rd_drive     = rd_drive_q;
  assign sense_strobe = strobe_q;
  assign wr_drive     = wr_drive_q;
  assign inhibit      = inhibit_q;
`ifdef CORE_PARITY_CHECK_EN
  assign parity_err   = parity_q;
`endif

endmodule

// File: tb/tb_core_cycle_ctrl.sv
// Self-checking bench for core_cycle_ctrl. The reference model tracks each
// granted request as "clocks since grant". From that count it derives which
// drive line must be active, with plain arithmetic on T_RD and T_WR.
module tb_core_cycle_ctrl;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 12;
  localparam int MEM_PAIRS = 10000;
  localparam int T_RD = 4;
  localparam int T_WR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, io_req = 1'b0, io_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0, io_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0, io_wdata = '0, sense = '0;
  logic cpu_ack, io_ack, err, busy, rd_drive, sense_strobe, wr_drive;
  logic [DATA_W-1:0] rdata, inhibit;
  logic [ADDR_W-1:0] core_addr;
`ifdef CORE_PARITY_CHECK_EN
  logic parity_err;
`endif

  always #5 clk = ~clk;

  core_cycle_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_PAIRS(MEM_PAIRS),
                    .T_RD(T_RD), .T_WR(T_WR)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_ack(io_ack),
    .rdata(rdata), .err(err), .busy(busy), .core_addr(core_addr),
    .rd_drive(rd_drive), .sense_strobe(sense_strobe), .wr_drive(wr_drive),
    .inhibit(inhibit), .sense(sense)
`ifdef CORE_PARITY_CHECK_EN
    , .parity_err(parity_err)
`endif
  );

  // ---------------- reference model ----------------
  bit m_active = 1'b0, m_oor = 1'b0, m_io = 1'b0, m_we = 1'b0, m_last_io = 1'b1, m_err = 1'b0;
  bit m_pick;
  int m_since = 0, m_len = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0, m_sensed = '0, m_rdata = '0;

  // Model: one transaction at a time, timed by clocks elapsed since its grant.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_oor <= 1'b0; m_io <= 1'b0; m_we <= 1'b0; m_last_io <= 1'b1;
      m_err <= 1'b0; m_since <= 0; m_len <= 0; m_addr <= '0; m_wdata <= '0;
      m_sensed <= '0; m_rdata <= '0;
    end else if (m_active) begin
      if (m_since == T_RD) m_sensed <= sense;
      if (m_since + 1 == m_len - 1) begin
        m_rdata <= m_sensed;
        m_err   <= 1'b0;
      end
      if (m_since + 1 == m_len) m_active <= 1'b0;
      m_since <= m_since + 1;
    end else if (cpu_req || io_req) begin
      m_pick = io_req && (!cpu_req || !m_last_io);
      m_last_io <= m_pick;
      m_io      <= m_pick;
      m_we      <= m_pick ? io_we : cpu_we;
      m_wdata   <= m_pick ? io_wdata : cpu_wdata;
      m_addr    <= m_pick ? io_addr : cpu_addr;
      m_active  <= 1'b1;
      m_since   <= 0;
      if (int'(m_pick ? io_addr : cpu_addr) >= MEM_PAIRS) begin
        m_oor <= 1'b1; m_len <= 1; m_rdata <= '0; m_err <= 1'b1;
      end else begin
        m_oor <= 1'b0; m_len <= T_RD + T_WR + 2;
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int rd_tot = 0, st_tot = 0, wr_tot = 0, ack_tot = 0;
  logic [DATA_W-1:0] last_inh = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    logic e_rd, e_st, e_wr, e_cack, e_iack;
    logic [DATA_W-1:0] e_inh;
    @(negedge clk);
    cyc++;
    e_rd   = m_active && !m_oor && (m_since < T_RD);
    e_st   = m_active && !m_oor && (m_since == T_RD);
    e_wr   = m_active && !m_oor && (m_since > T_RD) && (m_since <= T_RD + T_WR);
    e_inh  = e_wr ? ~(m_we ? m_wdata : m_sensed) : '0;
    e_cack = m_active && (m_since == m_len - 1) && !m_io;
    e_iack = m_active && (m_since == m_len - 1) && m_io;
    chk("rd_drive", rd_drive, e_rd);
    chk("sense_strobe", sense_strobe, e_st);
    chk("wr_drive", wr_drive, e_wr);
    chk("inhibit", inhibit, e_inh);
    chk("cpu_ack", cpu_ack, e_cack);
    chk("io_ack", io_ack, e_iack);
    chk("busy", busy, m_active);
    chk("rdata", rdata, m_rdata);
    chk("err", err, m_err);
    chk("core_addr", core_addr, m_addr);
    chk("rd_wr_overlap", rd_drive & wr_drive, 0);
    rd_tot += int'(rd_drive);
    st_tot += int'(sense_strobe);
    wr_tot += int'(wr_drive);
    ack_tot += int'(cpu_ack) + int'(io_ack);
    if (wr_drive) last_inh = inhibit;
  endtask

  // Issue one request from an idle controller and wait (bounded) for its ack.
  task automatic run_req(input bit use_io, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] sv,
                         output int lat, output bit ack_io);
    bit done;
    done = 1'b0; lat = 0; ack_io = 1'b0;
    sense = sv;
    if (use_io) begin io_req = 1'b1; io_we = we; io_addr = a; io_wdata = wd; end
    else begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (cpu_ack || io_ack) begin done = 1'b1; ack_io = io_ack; end
    end
    cpu_req = 1'b0; io_req = 1'b0;
    chk("ack_seen", done, 1);
    tick(); tick();
  endtask

  int lat, r0, s0, w0, a0, nacks;
  bit aio;
  bit who[3];
  int when[3];
  bit saw_wr;

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_rdata", rdata, 0);

    // Single CPU read: 4 RD, 1 strobe, 4 WR with ~data inhibit, ack at clock 10.
    r0 = rd_tot; s0 = st_tot; w0 = wr_tot;
    run_req(1'b0, 1'b0, 14'd5, 12'o0, 12'o1234, lat, aio);
    chk("rd_latency", lat, 10);
    chk("rd_acker_cpu", aio, 0);
    chk("rd_pulses", rd_tot - r0, 4);
    chk("strobe_pulses", st_tot - s0, 1);
    chk("wr_pulses", wr_tot - w0, 4);
    chk("rd_inhibit", last_inh, 12'o6543);
    chk("rd_rdata", rdata, 12'o1234);
    chk("rd_addr", core_addr, 5);

    // I/O write: inhibit follows write data, rdata returns the old contents.
    run_req(1'b1, 1'b1, 14'd100, 12'o0707, 12'o7777, lat, aio);
    chk("wr_latency", lat, 10);
    chk("wr_acker_io", aio, 1);
    chk("wr_inhibit", last_inh, 12'o7070);
    chk("wr_rdata", rdata, 12'o7777);

    // Both requesters held: CPU, IO, CPU, eleven clocks apart.
    sense = 12'o2222;
    cpu_we = 1'b0; cpu_addr = 14'd20; io_we = 1'b0; io_addr = 14'd30;
    cpu_req = 1'b1; io_req = 1'b1;
    nacks = 0;
    for (int t = 0; t < 100 && nacks < 3; t++) begin
      tick();
      if (cpu_ack || io_ack) begin who[nacks] = io_ack; when[nacks] = cyc; nacks++; end
    end
    cpu_req = 1'b0; io_req = 1'b0;
    chk("rr_count", nacks, 3);
    chk("rr_first_cpu", who[0], 0);
    chk("rr_second_io", who[1], 1);
    chk("rr_third_cpu", who[2], 0);
    chk("rr_space1", when[1] - when[0], 11);
    chk("rr_space2", when[2] - when[1], 11);
    tick(); tick();

    // Out-of-range: immediate ack with err, no drive pulses.
    r0 = rd_tot; s0 = st_tot; w0 = wr_tot;
    run_req(1'b0, 1'b0, 14'd10000, 12'o0, 12'o5555, lat, aio);
    chk("oor_latency", lat, 1);
    chk("oor_err", err, 1);
    chk("oor_rdata", rdata, 0);
    chk("oor_no_pulses", (rd_tot - r0) + (st_tot - s0) + (wr_tot - w0), 0);
    run_req(1'b1, 1'b0, 14'd16383, 12'o0, 12'o5555, lat, aio);
    chk("oor_max_latency", lat, 1);
    chk("oor_max_io", aio, 1);

    // Last valid address behaves normally and clears err.
    run_req(1'b0, 1'b1, 14'd9999, 12'o4321, 12'o1357, lat, aio);
    chk("edge_latency", lat, 10);
    chk("edge_err", err, 0);
    chk("edge_inhibit", last_inh, 12'o3456);
    chk("edge_rdata", rdata, 12'o1357);

    // Reset in the second WR clock removes all drives at once.
    sense = 12'o0033; cpu_we = 1'b0; cpu_addr = 14'd7; cpu_req = 1'b1;
    saw_wr = 1'b0;
    for (int t = 0; t < 20 && !saw_wr; t++) begin
      tick();
      saw_wr = wr_drive;
    end
    chk("rst_reached_wr", saw_wr, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_wr_drive", wr_drive, 0);
    chk("rst_rd_drive", rd_drive, 0);
    chk("rst_strobe", sense_strobe, 0);
    chk("rst_inhibit", inhibit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", cpu_ack | io_ack, 0);
    cpu_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    a0 = ack_tot;
    repeat (15) tick();
    chk("rst_no_ack", ack_tot - a0, 0);
    chk("rst_rdata", rdata, 0);
    run_req(1'b0, 1'b0, 14'd8, 12'o0, 12'o0107, lat, aio);
    chk("post_rst_latency", lat, 10);
    chk("post_rst_rdata", rdata, 12'o0107);

`ifdef CORE_PARITY_CHECK_EN
    chk("par_clear", parity_err, 0);
    run_req(1'b0, 1'b0, 14'd9, 12'o0, 12'b000000_100001, lat, aio);
    chk("par_set", parity_err, 1);
    chk("par_regen_rdata", rdata, 12'b000000_100001);
    run_req(1'b1, 1'b0, 14'd10, 12'o0, 12'o0101, lat, aio);
    chk("par_sticky", parity_err, 1);
    chk("par_good_rdata", rdata, 12'o0101);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
